// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner encoding and addr_mode encoding are used by both the arbiter and its
// grant decision block.
package dmem_pkg;

    // Owner of the most recent memory access.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // addr_mode values carried on the mode signals.
    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_BYTE = 1'b1;

    // Bit positions of each requester inside the request/grant vectors.
    localparam bit PORT_CPU = 1'b0;
    localparam bit PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant decision for the data-memory arbiter.
// Produces a one-hot (or zero) grant from the two requests, the DMA lock
// request, the previous owner and the current locked-grant count.
// Build option: define DMEM_ARB_RR_EN for round-robin on conflict; otherwise
// the CPU wins every unlocked conflict.
module dmem_arb_grant
    import dmem_pkg::*;
#(
    parameter int MAX_LOCK = 8,
    parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
    input  logic [1:0]       reqs_i,
    input  logic             lock_i,
    input  owner_t           last_owner_i,
    input  logic [CNT_W-1:0] lock_cnt_i,
    output logic [1:0]       gnt_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    logic dma_burst;

    // Priority decision: locked burst first, forced CPU slot at the lock limit, then policy.
    always_comb begin
        gnt_o     = 2'b00;
        dma_burst = reqs_i[PORT_DMA] & lock_i & (last_owner_i == OWN_DMA);
        if (dma_burst && (lock_cnt_i < MAX_CNT)) begin
            gnt_o[PORT_DMA] = 1'b1;
        end else if (dma_burst) begin
            // Lock limit reached: the CPU gets a slot if it wants one,
            // otherwise the DMA keeps going with the count saturated.
            if (reqs_i[PORT_CPU]) begin
                gnt_o[PORT_CPU] = 1'b1;
            end else begin
                gnt_o[PORT_DMA] = 1'b1;
            end
        end else if (reqs_i == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            if (last_owner_i == OWN_DMA) begin
                gnt_o[PORT_CPU] = 1'b1;
            end else begin
                gnt_o[PORT_DMA] = 1'b1;
            end
`else
            gnt_o[PORT_CPU] = 1'b1;
`endif
        end else begin
            gnt_o = reqs_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU (port 0) and DMA loader (port 1) share one
// memory port. Grants are combinational in the request cycle; load data is
// registered and returned to the owning port one cycle later.
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution
// (default build uses fixed CPU priority).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_LOCK      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic                     cpu_mode,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     dma_req,
    input  logic                     dma_we,
    input  logic                     dma_mode,
    input  logic [ADDRESS_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0]    dma_wdata,
    input  logic                     dma_lock,
    output logic                     dma_gnt,
    output logic                     dma_rvalid,
    output logic [DATA_WIDTH-1:0]    dma_rdata,
    output logic                     mem_we,
    output logic                     mem_mode,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    owner_t                  last_owner_q, last_owner_d;
    logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                    cpu_rvalid_q, cpu_rvalid_d;
    logic                    dma_rvalid_q, dma_rvalid_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
    logic [1:0]              gnt_raw;
    logic [1:0]              gnt;

    dmem_arb_grant #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_grant (
        .reqs_i       ({dma_req, cpu_req}),
        .lock_i       (dma_lock),
        .last_owner_i (last_owner_q),
        .lock_cnt_i   (lock_cnt_q),
        .gnt_o        (gnt_raw)
    );

    // Nothing is issued while reset is held, and a response registered just
    // before reset is suppressed.
    assign gnt        = rst ? 2'b00 : gnt_raw;
    assign cpu_gnt    = gnt[PORT_CPU];
    assign dma_gnt    = gnt[PORT_DMA];
    assign cpu_stall  = cpu_req & ~cpu_gnt & ~rst;
    assign cpu_rvalid = cpu_rvalid_q & ~rst;
    assign dma_rvalid = dma_rvalid_q & ~rst;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

    // Request mux: the granted DMA drives the port, otherwise the CPU fields pass through.
    always_comb begin
        mem_mode  = cpu_mode;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_gnt & cpu_we;
        if (dma_gnt) begin
            mem_mode  = dma_mode;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end
    end

    // Next-state for ownership, lock counting and response routing.
    always_comb begin
        last_owner_d = last_owner_q;
        lock_cnt_d   = lock_cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        dma_rvalid_d = dma_gnt & ~dma_we;

        if (cpu_gnt) begin
            last_owner_d = OWN_CPU;
        end else if (dma_gnt) begin
            last_owner_d = OWN_DMA;
        end

        // Only grants taken while already the locked owner count toward the limit.
        if (cpu_gnt || !(dma_req && dma_lock)) begin
            lock_cnt_d = '0;
        end else if (dma_gnt && (last_owner_q == OWN_DMA) && (lock_cnt_q < MAX_CNT)) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end

        if (cpu_gnt && !cpu_we) begin
            cpu_rdata_d = mem_rdata;
        end
        if (dma_gnt && !dma_we) begin
            dma_rdata_d = mem_rdata;
        end
    end

    // State registers; reset makes the DMA the last owner so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_DMA;
            lock_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressable memory model
// and a response scoreboard. Expectations for conflicting requests follow the
// DMEM_ARB_RR_EN build option.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_mode;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_mode, dma_lock;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_we, mem_mode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        mem_init;
    logic [31:0] mem [64];

    typedef struct {
        logic        cv;
        logic        dv;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_c, exp_d;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MAX_LOCK      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_mode   (cpu_mode),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_mode   (dma_mode),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_we     (mem_we),
        .mem_mode   (mem_mode),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: image load during the first reset cycle, word/byte stores.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h1111_1111;
            mem[1] <= 32'h2222_2222;
            mem[2] <= 32'h3333_3333;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (mem_we) begin
            if (mem_mode == MODE_BYTE)
                mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
            else
                mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // Combinational read port.
    always_comb begin
        mem_rdata = mem[mem_addr[7:2]];
        if (mem_mode == MODE_BYTE)
            mem_rdata = {24'h0, mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8]};
    end

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic m);
        logic [31:0] w;
        w = mem[a[7:2]];
        if (m == MODE_BYTE) return {24'h0, w[8*a[1:0] +: 8]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic mode,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_we = we; cpu_mode = mode; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic mode,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
        dma_req = req; dma_we = we; dma_mode = mode; dma_addr = addr; dma_wdata = wdata;
        dma_lock = lock;
    endtask

    // One clock cycle: check request-cycle outputs, retire the previous
    // response from the scoreboard, queue this cycle's expected response.
    task automatic cyc(input logic eg_c, input logic eg_d, input string tag);
        resp_t e, n;
        logic  rst_now, exp_we;
        @(negedge clk);
        rst_now = rst;
        chk({tag, "_cgnt"}, {31'h0, cpu_gnt}, {31'h0, eg_c});
        chk({tag, "_dgnt"}, {31'h0, dma_gnt}, {31'h0, eg_d});
        chk({tag, "_stall"}, {31'h0, cpu_stall}, {31'h0, cpu_req & ~eg_c & ~rst_now});
        exp_we = (eg_c & cpu_we) | (eg_d & dma_we);
        chk({tag, "_mwe"}, {31'h0, mem_we}, {31'h0, exp_we});
        chk({tag, "_maddr"}, mem_addr, eg_d ? dma_addr : cpu_addr);
        chk({tag, "_mmode"}, {31'h0, mem_mode}, {31'h0, eg_d ? dma_mode : cpu_mode});
        if (exp_we) chk({tag, "_mwdata"}, mem_wdata, eg_d ? dma_wdata : cpu_wdata);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_crv"}, {31'h0, cpu_rvalid}, {31'h0, e.cv & ~rst_now});
            chk({tag, "_drv"}, {31'h0, dma_rvalid}, {31'h0, e.dv & ~rst_now});
            if (!rst_now) begin
                if (e.cv) exp_c = e.data;
                if (e.dv) exp_d = e.data;
                chk({tag, "_crd"}, cpu_rdata, exp_c);
                chk({tag, "_drd"}, dma_rdata, exp_d);
            end
        end
        n.cv   = eg_c & ~cpu_we;
        n.dv   = eg_d & ~dma_we;
        n.data = n.cv ? model_read(cpu_addr, cpu_mode)
               : (n.dv ? model_read(dma_addr, dma_mode) : 32'h0);
        sb.push_back(n);
        @(posedge clk);
        #1;
        if (rst_now) begin
            exp_c = 32'h0;
            exp_d = 32'h0;
        end
    endtask

    initial begin
        exp_c = 32'h0;
        exp_d = 32'h0;
        rst = 1'b1;
        mem_init = 1'b1;
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        sb.push_back('{cv: 1'b0, dv: 1'b0, data: 32'h0});

        // Reset: two cycles, requests during reset must not be granted.
        cyc(0, 0, "rst0");
        mem_init = 1'b0;
        set_cpu(1, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(1, 0, MODE_WORD, 32'h4, 32'h0, 1);
        cyc(0, 0, "rst1");

        // 1: CPU load from 0x10.
        rst = 1'b0;
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        set_cpu(1, 0, MODE_WORD, 32'h10, 32'h0);
        cyc(1, 0, "t1_ld");
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        cyc(0, 0, "t1_resp");
        chk("t1_data", cpu_rdata, 32'hDEAD_BEEF);

        // 2: unlocked conflict for four cycles.
        set_cpu(1, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(1, 0, MODE_WORD, 32'h4, 32'h0, 0);
`ifdef DMEM_ARB_RR_EN
        cyc(0, 1, "t2_0"); cyc(1, 0, "t2_1"); cyc(0, 1, "t2_2"); cyc(1, 0, "t2_3");
`else
        for (int i = 0; i < 4; i++) cyc(1, 0, "t2_fix");
`endif
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        cyc(0, 0, "t2_flush");

        // 3: locked DMA burst against a constantly requesting CPU.
        set_dma(1, 0, MODE_WORD, 32'h8, 32'h0, 1);
        cyc(0, 1, "t3_first");
        set_cpu(1, 0, MODE_WORD, 32'h4, 32'h0);
        for (int i = 0; i < 8; i++) cyc(0, 1, "t3_lock");
        cyc(1, 0, "t3_release");
`ifdef DMEM_ARB_RR_EN
        cyc(0, 1, "t3_resume0"); cyc(0, 1, "t3_resume1");
`else
        cyc(1, 0, "t3_cpu0"); cyc(1, 0, "t3_cpu1");
`endif
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        cyc(0, 0, "t3_flush");

        // Lock count saturates with no CPU request, CPU still gets the next slot.
        set_dma(1, 0, MODE_WORD, 32'h10, 32'h0, 1);
        for (int i = 0; i < 11; i++) cyc(0, 1, "sat_d");
        set_cpu(1, 0, MODE_WORD, 32'h0, 32'h0);
        cyc(1, 0, "sat_c");

        // dma_lock without dma_req has no effect.
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 1);
        set_cpu(1, 0, MODE_WORD, 32'h8, 32'h0);
        cyc(1, 0, "lock_noreq");

        // 4: DMA byte store then CPU word load of the same word.
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(1, 1, MODE_BYTE, 32'h21, 32'h0000_00A5, 0);
        cyc(0, 1, "t4_st");
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        set_cpu(1, 0, MODE_WORD, 32'h20, 32'h0);
        cyc(1, 0, "t4_ld");
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        cyc(0, 0, "t4_resp");
        chk("t4_byte", cpu_rdata, 32'h0000_A500);

        // 5: DMA load, then reset drops the response; CPU wins the first tie.
        set_dma(1, 0, MODE_WORD, 32'h10, 32'h0, 0);
        cyc(0, 1, "t5_ld");
        rst = 1'b1;
        set_cpu(1, 0, MODE_WORD, 32'h4, 32'h0);
        cyc(0, 0, "t5_rst");
        rst = 1'b0;
        cyc(1, 0, "t5_tie");
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        cyc(0, 0, "t5_resp");
        chk("t5_drd", dma_rdata, 32'h0);

        // 6: back-to-back CPU loads.
        set_cpu(1, 0, MODE_WORD, 32'h0, 32'h0);
        cyc(1, 0, "t6_a0");
        set_cpu(1, 0, MODE_WORD, 32'h4, 32'h0);
        cyc(1, 0, "t6_a4");
        set_cpu(1, 0, MODE_WORD, 32'h8, 32'h0);
        cyc(1, 0, "t6_a8");
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        cyc(0, 0, "t6_flush");
        chk("t6_last", cpu_rdata, 32'h3333_3333);

        // Back-to-back loads to different owners.
        set_cpu(1, 0, MODE_WORD, 32'h4, 32'h0);
        cyc(1, 0, "t7_c");
        set_cpu(0, 0, MODE_WORD, 32'h0, 32'h0);
        set_dma(1, 0, MODE_WORD, 32'h8, 32'h0, 0);
        cyc(0, 1, "t7_d");
        set_dma(0, 0, MODE_WORD, 32'h0, 32'h0, 0);
        cyc(0, 0, "t7_flush");
        chk("t7_crd", cpu_rdata, 32'h2222_2222);
        chk("t7_drd", dma_rdata, 32'h3333_3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
